// File: rtl/pc_sequencer_if.sv
// Bus bundle between the instruction-cycle controller and the rest of the CPU:
// memory, register file/ALU datapath, flag register and program counter.
//
// Memory handshake: the controller holds a memory access (address select and,
// for stores, mem_we) asserted every cycle until mem_ready is seen high; the
// access completes in the cycle where mem_ready=1, and nothing from that access
// is repeated after it. mem_ready is ignored outside FETCH and MEM.
interface pc_sequencer_if;
  logic        run;
  logic [15:0] pc_cur;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        flag_z;
  logic        flag_n;
  logic [15:0] reg_target;
  logic [15:0] ir;
  logic [15:0] in_pc;
  logic        en_pc;
  logic        mem_addr_sel;
  logic        mem_we;
  logic        reg_we;
  logic        flags_en;
  logic        halted;
  logic [2:0]  state;

  // Controller side
  modport master (
    input  run, pc_cur, mem_rdata, mem_ready, flag_z, flag_n, reg_target,
    output ir, in_pc, en_pc, mem_addr_sel, mem_we, reg_we, flags_en, halted, state
  );

  // Datapath / memory / program-counter side
  modport slave (
    output run, pc_cur, mem_rdata, mem_ready, flag_z, flag_n, reg_target,
    input  ir, in_pc, en_pc, mem_addr_sel, mem_we, reg_we, flags_en, halted, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit CPU. Holds the instruction
// register, computes the next PC and produces the datapath write strobes.
// state and ir are registered; every strobe and in_pc is combinational.
module pc_sequencer (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BZ    = 4'hA;
  localparam logic [3:0] OP_BN    = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [15:0] ir_q;
  logic [3:0]  opcode;
  logic [15:0] pc_inc;
  logic [15:0] branch_offset;
  logic [15:0] pc_branch;

  logic [15:0] in_pc;
  logic        en_pc;
  logic        mem_addr_sel;
  logic        mem_we;
  logic        reg_we;
  logic        flags_en;

  assign opcode        = ir_q[15:12];
  assign pc_inc        = bus.pc_cur + 16'd1;
  assign branch_offset = {{8{ir_q[7]}}, ir_q[7:0]};
  assign pc_branch     = bus.pc_cur + branch_offset;

  // Next-state selection; unused codes 6/7 fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
        else if (opcode == OP_HALT)                  state_d = S_HALT;
        else                                         state_d = S_FETCH;
      end
      S_MEM:    state_d = bus.mem_ready ? S_FETCH : S_MEM;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and instruction register; ir loads only when the fetch completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && bus.mem_ready) ir_q <= bus.mem_rdata;
    end
  end

  // Strobes and next-PC value decoded from the current state and instruction.
  always_comb begin
    in_pc        = pc_inc;
    en_pc        = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    flags_en     = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (opcode <= 4'h7) begin
          reg_we   = 1'b1;
          flags_en = 1'b1;
          en_pc    = 1'b1;
        end else if (opcode == OP_BZ) begin
          en_pc = 1'b1;
          if (bus.flag_z) in_pc = pc_branch;
        end else if (opcode == OP_BN) begin
          en_pc = 1'b1;
          if (bus.flag_n) in_pc = pc_branch;
        end else if (opcode == OP_JMP) begin
          en_pc = 1'b1;
          in_pc = bus.reg_target;
        end else if (opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_HALT) begin
          en_pc = 1'b0;
        end else begin
          // 0xD and 0xE behave as NOP
          en_pc = 1'b1;
        end
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        reg_we       = (opcode == OP_LOAD) && bus.mem_ready;
        en_pc        = bus.mem_ready;
      end
      default: begin
        in_pc = pc_inc;
      end
    endcase
  end

  assign bus.ir           = ir_q;
  assign bus.state        = state_q;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.in_pc        = in_pc;
  assign bus.en_pc        = en_pc;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.mem_we       = mem_we;
  assign bus.reg_we       = reg_we;
  assign bus.flags_en     = flags_en;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer. Instruction results are
// predicted from the instruction-set rules with integer arithmetic.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] cur_ir;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one EXEC cycle from the instruction-set rules.
  function automatic void exec_model(input logic [15:0] instr, input logic [15:0] pc,
                                     input logic z, input logic n, input logic [15:0] tgt,
                                     output logic en, output logic [15:0] npc,
                                     output logic rw, output logic fe);
    int op;
    int off;
    int p;
    op  = int'(instr[15:12]);
    p   = int'(pc);
    en  = 1'b1;
    rw  = 1'b0;
    fe  = 1'b0;
    npc = 16'((p + 1) % 65536);
    if (op <= 7) begin
      rw = 1'b1;
      fe = 1'b1;
    end else if (op == 8 || op == 9 || op == 15) begin
      en = 1'b0;
    end else if (op == 10 || op == 11) begin
      off = int'(instr[7:0]);
      if (off >= 128) off = off - 256;
      if ((op == 10 && z) || (op == 11 && n)) npc = 16'((p + off + 65536) % 65536);
    end else if (op == 12) begin
      npc = tgt;
    end
  endfunction

  // Runs one instruction starting in the first FETCH cycle (just after the edge).
  task automatic do_instr(input logic [15:0] instr, input logic [15:0] pc,
                          input logic z, input logic n, input logic [15:0] tgt,
                          input int fw, input int mw);
    logic        e_en;
    logic        e_rw;
    logic        e_fe;
    logic [15:0] e_pc;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    is_load  = (instr[15:12] == 4'h8);
    is_store = (instr[15:12] == 4'h9);
    is_halt  = (instr[15:12] == 4'hF);
    bus.pc_cur    = pc;
    bus.mem_rdata = instr;
    bus.run       = 1'($urandom);
    for (int k = 0; k <= fw; k++) begin
      bus.mem_ready = (k == fw);
      #1;
      chk_state("fetch_state", bus.state, 3'd1);
      chk1("fetch_sel", bus.mem_addr_sel, 1'b0);
      chk1("fetch_en_pc", bus.en_pc, 1'b0);
      chk1("fetch_reg_we", bus.reg_we, 1'b0);
      chk16("fetch_ir_hold", bus.ir, cur_ir);
      tick;
    end
    cur_ir = instr;
    bus.mem_rdata = 16'($urandom);
    bus.mem_ready = 1'($urandom);
    #1;
    chk_state("decode_state", bus.state, 3'd2);
    chk16("decode_ir", bus.ir, instr);
    chk1("decode_en_pc", bus.en_pc, 1'b0);
    chk1("decode_reg_we", bus.reg_we, 1'b0);
    chk1("decode_flags_en", bus.flags_en, 1'b0);
    chk1("decode_mem_we", bus.mem_we, 1'b0);
    tick;
    bus.flag_z     = z;
    bus.flag_n     = n;
    bus.reg_target = tgt;
    bus.mem_ready  = 1'($urandom);
    exec_model(instr, pc, z, n, tgt, e_en, e_pc, e_rw, e_fe);
    #1;
    chk_state("exec_state", bus.state, 3'd3);
    chk1("exec_en_pc", bus.en_pc, e_en);
    chk16("exec_in_pc", bus.in_pc, e_pc);
    chk1("exec_reg_we", bus.reg_we, e_rw);
    chk1("exec_flags_en", bus.flags_en, e_fe);
    chk1("exec_mem_we", bus.mem_we, 1'b0);
    tick;
    if (is_load || is_store) begin
      for (int k = 0; k <= mw; k++) begin
        bus.mem_ready = (k == mw);
        bus.flag_z    = 1'($urandom);
        bus.flag_n    = 1'($urandom);
        #1;
        chk_state("mem_state", bus.state, 3'd4);
        chk1("mem_sel", bus.mem_addr_sel, 1'b1);
        chk1("mem_we", bus.mem_we, is_store);
        chk1("mem_reg_we", bus.reg_we, is_load && (k == mw));
        chk1("mem_en_pc", bus.en_pc, k == mw);
        chk1("mem_flags_en", bus.flags_en, 1'b0);
        chk16("mem_in_pc", bus.in_pc, 16'((int'(pc) + 1) % 65536));
        tick;
      end
    end
    if (!is_halt) begin
      bus.pc_cur = 16'($urandom);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cur_ir = 16'h0000;
    reset = 1'b1;
    bus.run = 1'b1;
    bus.pc_cur = 16'h0010;
    bus.mem_rdata = 16'h0000;
    bus.mem_ready = 1'b1;
    bus.flag_z = 1'b0;
    bus.flag_n = 1'b0;
    bus.reg_target = 16'h0000;

    // Reset with run high holds IDLE
    #1 reset = 1'b0;
    #1;
    chk_state("rst_state", bus.state, 3'd0);
    chk16("rst_ir", bus.ir, 16'h0000);
    chk1("rst_en_pc", bus.en_pc, 1'b0);
    chk1("rst_reg_we", bus.reg_we, 1'b0);
    chk1("rst_flags_en", bus.flags_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_sel", bus.mem_addr_sel, 1'b0);
    chk1("rst_halted", bus.halted, 1'b0);
    chk16("rst_in_pc", bus.in_pc, 16'h0011);
    tick;
    chk_state("rst_hold_state", bus.state, 3'd0);
    reset = 1'b1;
    bus.run = 1'b0;
    tick;
    chk_state("idle_no_run", bus.state, 3'd0);
    bus.run = 1'b1;
    tick;

    // ALU, branches, NOP wrap, JMP
    do_instr(16'h1234, 16'h0010, 1'b0, 1'b0, 16'h0000, 0, 0);
    do_instr(16'hA0FC, 16'h0002, 1'b1, 1'b0, 16'h0000, 0, 0);
    do_instr(16'hA0FC, 16'h0002, 1'b0, 1'b1, 16'h0000, 0, 0);
    do_instr(16'hB005, 16'h0100, 1'b0, 1'b1, 16'h0000, 0, 0);
    do_instr(16'hE000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 0, 0);
    do_instr(16'hC000, 16'h0020, 1'b0, 1'b0, 16'h4321, 0, 0);

    // Memory waits
    do_instr(16'h9000, 16'h0030, 1'b0, 1'b0, 16'h0000, 0, 3);
    do_instr(16'h8123, 16'h0031, 1'b0, 1'b0, 16'h0000, 2, 2);

    // Randomized instruction stream (no HALT)
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 14));
      do_instr(ins, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a STORE wait
    bus.pc_cur = 16'h0040;
    bus.mem_rdata = 16'h9000;
    bus.mem_ready = 1'b1;
    tick;
    tick;
    tick;
    bus.mem_ready = 1'b0;
    #1;
    chk_state("mid_store_state", bus.state, 3'd4);
    chk1("mid_store_we", bus.mem_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_we", bus.mem_we, 1'b0);
    chk_state("mid_rst_state", bus.state, 3'd0);
    chk16("mid_rst_ir", bus.ir, 16'h0000);
    chk1("mid_rst_en_pc", bus.en_pc, 1'b0);
    chk1("mid_rst_sel", bus.mem_addr_sel, 1'b0);
    bus.mem_ready = 1'b1;
    tick;
    chk1("mid_rst_en_pc_hold", bus.en_pc, 1'b0);
    cur_ir = 16'h0000;
    reset = 1'b1;
    bus.run = 1'b1;
    tick;

    // HALT: sticky, run ignored
    do_instr(16'hF000, 16'h0050, 1'b0, 1'b0, 16'h0000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      bus.run = 1'(i % 2);
      bus.mem_ready = 1'($urandom);
      #1;
      chk_state("halt_state", bus.state, 3'd5);
      chk1("halt_halted", bus.halted, 1'b1);
      chk1("halt_en_pc", bus.en_pc, 1'b0);
      chk1("halt_reg_we", bus.reg_we, 1'b0);
      chk1("halt_mem_we", bus.mem_we, 1'b0);
      tick;
    end
    #2 reset = 1'b0;
    #1;
    chk_state("halt_rst_state", bus.state, 3'd0);
    chk1("halt_rst_halted", bus.halted, 1'b0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
